canvas_access_arbiter: RTL
==========================

Name: canvas_access_arbiter

Overview:
- Owns the single-port canvas cell RAM: 40x30 cells, 3-bit colour each, synchronous read.
- Shares the RAM between the VGA scan fetch (highest priority), the brush writer and the full-canvas clear sequencer.
- Expands one draw command into a 1x1 or 3x3 write burst, with edge clipping.
- Sits between the cursor/button logic (slow domain, already synchronised to clk) and the VGA pixel pipeline.

Parameters:
- COLS, 40, canvas width in cells.
- ROWS, 30, canvas height in cells.
- COLOR_W, 3, cell colour width.
- CLEAR_COLOR, 3'b111, colour written by a clear sweep.
- CLEAR_ON_RESET, 1, when 1 a clear sweep starts automatically after reset.

Ports:
- clk  in  1  pixel clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- vga_req  in  1  VGA fetch request, this cycle.
- vga_col  in  6  fetch column, 0..COLS-1.
- vga_row  in  5  fetch row, 0..ROWS-1.
- vga_valid  out  1  vga_data valid; one cycle after the accepted vga_req.
- vga_data  out  COLOR_W  fetched cell colour.
- draw_req  in  1  draw command request.
- draw_col  in  6  brush centre column.
- draw_row  in  5  brush centre row.
- draw_size  in  1  0 = 1x1 brush, 1 = 3x3 brush.
- draw_color  in  COLOR_W  brush colour.
- draw_ready  out  1  arbiter can accept a command (draw or clear).
- clear_req  in  1  request a full-canvas clear.
- busy  out  1  brush burst or clear sweep in progress.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  11  RAM address = row*COLS + col.
- mem_wdata  out  COLOR_W  RAM write data.
- mem_rdata  in  COLOR_W  RAM read data, valid one cycle after a read with mem_en=1, mem_we=0.

Behaviour:
- Reset values:
  - vga_valid=0, vga_data=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - draw_ready=0 while reset is high.
  - FSM goes to CLEAR (addr counter 0) if CLEAR_ON_RESET=1, otherwise IDLE.
- Reset mid-burst or mid-sweep aborts immediately; the partial writes are not rolled back.
- FSM states:
  - IDLE: draw_ready=1, busy=0.
  - BRUSH: draw_ready=0, busy=1.
  - CLEAR: draw_ready=0, busy=1.
- Acceptance:
  - Accepts only in IDLE.
  - If clear_req and draw_req are high in the same cycle, clear wins; the draw is not accepted (requester holds it).
  - Draw accept: latch col, row, size and colour, enter BRUSH, offset index k=0.
- Port grant each cycle:
  - If vga_req=1, the VGA read owns the RAM: mem_en=1, mem_we=0, mem_addr=vga_row*COLS+vga_col.
  - Otherwise the FSM write slot owns it. Writes never preempt VGA.
- VGA read latency is exactly 1: vga_valid=1 and vga_data=mem_rdata on the next cycle.
  - vga_data is registered and holds its last value when vga_valid=0.
  - Back-to-back vga_req gives back-to-back vga_valid.
- BRUSH:
  - size=0: one slot at the centre cell.
  - size=1: 9 slots in row-major order, dy=-1..+1 outer, dx=-1..+1 inner.
  - A slot whose cell is out of range (col<0, col>=COLS, row<0, row>=ROWS) is skipped: k advances in one cycle, mem_en=0, grant not required.
  - An in-range slot writes draw_color and advances k only on a cycle with vga_req=0; otherwise it stalls.
  - After the last slot, return to IDLE. draw_ready rises the cycle after the final write/skip.
- CLEAR:
  - Sweeps addresses 0..COLS*ROWS-1 (1199), writing CLEAR_COLOR. Advances only on granted cycles.
  - After address 1199 is written, go to IDLE.
- Width rules:
  - Offset arithmetic is signed 7-bit for columns and 6-bit for rows, so -1 and wrap cases are detected without aliasing.
  - Out-of-range centre coordinates from the requester produce only skips; there is no wrap-around to the opposite edge.
- No write to an address ever coincides with a VGA read of it in the same cycle, because only one access happens per cycle.

Test Plan:
- Reset with CLEAR_ON_RESET=1, vga_req=0 -> exactly 1200 writes of 3'b111 to addr 0..1199 in consecutive cycles; draw_ready rises on cycle 1201 after reset release.
- In IDLE, draw col=10 row=5 size=0 colour=3'b010 -> one write at addr 210, data 3'b010; busy high for 1 cycle.
- Draw col=0 row=0 size=1 colour=3'b001 -> writes only at addr 0, 1, 40, 41 in that order; 9 slot cycles total; 5 skips with mem_en=0.
- Draw col=39 row=29 size=1 while vga_req toggles 1,0,1,0... -> writes at 1158, 1159, 1198, 1199 occur only on vga_req=0 cycles; every vga_req yields vga_valid the next cycle with correct data.
- clear_req and draw_req together in IDLE -> clear sweep runs and the draw is not accepted; the held draw is accepted after the sweep and wins over later colours.
- Reset asserted mid-3x3 burst after 2 writes -> the next cycle shows mem_en=0, draw_ready=0, then a clear sweep from addr 0.

Source files
------------

// File: rtl/canvas_access_arbiter.sv
// canvas_access_arbiter
//   Owns the single-port 40x30 canvas cell RAM. In priority order it shares the
//   port between the VGA scan fetch, the brush writer (1x1 or 3x3 burst with
//   edge clipping) and the full-canvas clear sweeper.
// Ports:
//   clk, reset                 pixel clock, synchronous active-high reset
//   vga_req/col/row            fetch request, served in the same cycle
//   vga_valid/data             fetch result, one cycle later
//   draw_req/col/row/size/color, draw_ready   brush command handshake
//   clear_req                  full-canvas clear request
//   busy                       burst or sweep in progress
//   mem_en/we/addr/wdata/rdata RAM port (synchronous read, 1-cycle latency)
module canvas_access_arbiter #(
  parameter int                 COLS           = 40,
  parameter int                 ROWS           = 30,
  parameter int                 COLOR_W        = 3,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR    = 3'b111,
  parameter bit                 CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vga_req,
  input  logic [5:0]         vga_col,
  input  logic [4:0]         vga_row,
  output logic               vga_valid,
  output logic [COLOR_W-1:0] vga_data,
  input  logic               draw_req,
  input  logic [5:0]         draw_col,
  input  logic [4:0]         draw_row,
  input  logic               draw_size,
  input  logic [COLOR_W-1:0] draw_color,
  output logic               draw_ready,
  input  logic               clear_req,
  output logic               busy,
  output logic               mem_en,
  output logic               mem_we,
  output logic [10:0]        mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata
);
  localparam logic [10:0]       LAST_ADDR = 11'(COLS * ROWS - 1);
  localparam logic signed [6:0] COLS_S    = 7'(COLS);
  localparam logic signed [5:0] ROWS_S    = 6'(ROWS);

  typedef enum logic [1:0] {IDLE, BRUSH, CLEAR} state_t;

  state_t             state, state_nxt;
  logic [5:0]         b_col;
  logic [4:0]         b_row;
  logic               b_size;
  logic [COLOR_W-1:0] b_color;
  logic [3:0]         k, k_nxt;
  logic [10:0]        clr_addr, clr_addr_nxt;
  logic               accept_draw;

  logic               vga_valid_q;
  logic [COLOR_W-1:0] vga_hold;
  logic [10:0]        vga_addr;

  logic signed [6:0]  dx, slot_col;
  logic signed [5:0]  dy, slot_row;
  logic               slot_in, slot_last;
  logic [10:0]        slot_addr;

  assign vga_addr = 11'(11'(vga_row) * 11'(COLS)) + 11'(vga_col);

  // Brush offsets for slot k, row-major over the 3x3 window.
  always_comb begin
    dx = '0;
    dy = '0;
    if (b_size) begin
      case (k)
        4'd0, 4'd1, 4'd2: dy = -6'sd1;
        4'd3, 4'd4, 4'd5: dy = 6'sd0;
        default:          dy = 6'sd1;
      endcase
      case (k)
        4'd0, 4'd3, 4'd6: dx = -7'sd1;
        4'd1, 4'd4, 4'd7: dx = 7'sd0;
        default:          dx = 7'sd1;
      endcase
    end
  end

  // Coordinates are widened by one sign bit so that -1 and past-the-edge cells
  // are rejected rather than aliased onto the opposite edge.
  assign slot_col  = $signed({1'b0, b_col}) + dx;
  assign slot_row  = $signed({1'b0, b_row}) + dy;
  assign slot_in   = (slot_col >= 7'sd0) && (slot_col < COLS_S) &&
                     (slot_row >= 6'sd0) && (slot_row < ROWS_S);
  assign slot_addr = 11'(11'(slot_row[4:0]) * 11'(COLS)) + 11'(slot_col[5:0]);
  assign slot_last = !b_size || (k == 4'd8);

  // Port grant and next-state. VGA always wins the port; the FSM write slot
  // only proceeds on cycles without a fetch. Skipped (clipped) brush slots
  // need no port and advance regardless.
  always_comb begin
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    state_nxt    = state;
    k_nxt        = k;
    clr_addr_nxt = clr_addr;
    accept_draw  = 1'b0;
    if (!reset) begin
      if (vga_req) begin
        mem_en   = 1'b1;
        mem_addr = vga_addr;
      end
      case (state)
        IDLE: begin
          if (clear_req) begin
            state_nxt    = CLEAR;
            clr_addr_nxt = '0;
          end else if (draw_req) begin
            accept_draw = 1'b1;
            state_nxt   = BRUSH;
            k_nxt       = '0;
          end
        end
        BRUSH: begin
          if (!slot_in || !vga_req) begin
            if (slot_in) begin
              mem_en    = 1'b1;
              mem_we    = 1'b1;
              mem_addr  = slot_addr;
              mem_wdata = b_color;
            end
            if (slot_last) state_nxt = IDLE;
            else           k_nxt     = k + 4'd1;
          end
        end
        CLEAR: begin
          if (!vga_req) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_addr;
            mem_wdata = CLEAR_COLOR;
            if (clr_addr == LAST_ADDR) state_nxt    = IDLE;
            else                       clr_addr_nxt = clr_addr + 11'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR_ON_RESET ? CLEAR : IDLE;
      k           <= '0;
      clr_addr    <= '0;
      b_col       <= '0;
      b_row       <= '0;
      b_size      <= 1'b0;
      b_color     <= '0;
      vga_valid_q <= 1'b0;
      vga_hold    <= '0;
    end else begin
      state       <= state_nxt;
      k           <= k_nxt;
      clr_addr    <= clr_addr_nxt;
      vga_valid_q <= vga_req;
      if (vga_valid_q) vga_hold <= mem_rdata;
      if (accept_draw) begin
        b_col   <= draw_col;
        b_row   <= draw_row;
        b_size  <= draw_size;
        b_color <= draw_color;
      end
    end
  end

  // RAM read data arrives the cycle after the fetch; pass it through while
  // valid and hold the last fetched colour otherwise.
  assign vga_valid  = vga_valid_q;
  assign vga_data   = vga_valid_q ? mem_rdata : vga_hold;
  assign draw_ready = !reset && (state == IDLE);
  assign busy       = (state != IDLE);

endmodule
